// File: rtl/ahsqr_k4_isqrt.sv
// Approximate hybrid integer square root, k=4: 16-bit radicand to 8-bit root.
// The upper root nibble is exact. The lower nibble is a shifted partial remainder.
module ahsqr_k4_isqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] R,
  output logic [7:0]  final_op
);

  logic [7:0] hi_byte;
  logic [7:0] lo_byte;
  logic       hi_zero;

  logic [7:0] sq_in;
  logic [3:0] sq_root;
  logic [5:0] sq_rem;
  logic [5:0] acc;

  logic [1:0] lead_pos;
  logic [8:0] t_ext;
  logic [8:0] t_shift;
  logic [3:0] q_low;
  logic [7:0] next_op;

  assign hi_byte = R[15:8];
  assign lo_byte = R[7:0];
  assign hi_zero = (hi_byte == 8'd0);

  // A single root unit is shared between the high byte and the low byte.
  assign sq_in = hi_zero ? lo_byte : hi_byte;

  // Restoring root, two radicand bits per step. The partial remainder stays below 32.
  always_comb begin
    acc     = '0;
    sq_root = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc = {acc[3:0], sq_in[7 - 2*i -: 2]};
      if (acc >= {sq_root, 2'b01}) begin
        acc     = acc - {sq_root, 2'b01};
        sq_root = {sq_root[2:0], 1'b1};
      end else begin
        sq_root = {sq_root[2:0], 1'b0};
      end
    end
    sq_rem = acc;
  end

  always_comb begin
    if (sq_root[3])
      lead_pos = 2'd3;
    else if (sq_root[2])
      lead_pos = 2'd2;
    else if (sq_root[1])
      lead_pos = 2'd1;
    else
      lead_pos = 2'd0;
  end

  // The top bit of sq_rem is always zero. It is carried through so the saturation
  // compare sees the full value.
  assign t_ext   = {sq_rem, lo_byte[7:5]};
  assign t_shift = t_ext >> lead_pos;
  assign q_low   = (t_shift > 9'd15) ? 4'd15 : t_shift[3:0];

  assign next_op = hi_zero ? {4'd0, sq_root} : {sq_root, q_low};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      final_op <= '0;
    else
      final_op <= next_op;
  end

endmodule

// File: tb/tb_ahsqr_k4_isqrt.sv
// Self-checking bench for ahsqr_k4_isqrt.
// It uses directed vectors plus an exhaustive sweep against an independent model.
`timescale 1ns/1ps
module tb_ahsqr_k4_isqrt;

  logic        clk;
  logic        rst;
  logic [15:0] R;
  logic [7:0]  final_op;

  int n_vec;
  int n_err;

  ahsqr_k4_isqrt dut (
    .clk      (clk),
    .rst      (rst),
    .R        (R),
    .final_op (final_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int isqrt_int(input int x);
    int q;
    q = 0;
    while ((q + 1) * (q + 1) <= x) q++;
    return q;
  endfunction

  function automatic int model(input int r);
    int h, l, qh, rem, t, p, ql;
    h = r / 256;
    l = r % 256;
    if (h == 0) return isqrt_int(l);
    qh  = isqrt_int(h);
    rem = h - qh * qh;
    t   = rem * 8 + l / 32;
    p   = 0;
    while ((1 << (p + 1)) <= qh) p++;
    ql = t / (1 << p);
    if (ql > 15) ql = 15;
    return qh * 16 + ql;
  endfunction

  task automatic test_reset;
    R   = 16'hFFFF;
    rst = 1'b1;
    #3;
    n_vec++;
    if (final_op !== 8'd0) begin
      n_err++;
      $display("FAIL reset_async: got %0d want 0", final_op);
    end
    @(posedge clk); #1;
    n_vec++;
    if (final_op !== 8'd0) begin
      n_err++;
      $display("FAIL reset_held: got %0d want 0", final_op);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (final_op !== 8'd255) begin
      n_err++;
      $display("FAIL reset_first_edge: got %0d want 255", final_op);
    end
  endtask

  task automatic test_low_range;
    logic [15:0] vin [5];
    logic [7:0]  vexp [5];
    vin  = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd255};
    vexp = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd15};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      R = vin[i];
      @(posedge clk); #1;
      n_vec++;
      if (final_op !== vexp[i]) begin
        n_err++;
        $display("FAIL low_range R=%0d: got %0d want %0d", vin[i], final_op, vexp[i]);
      end
    end
  endtask

  task automatic test_high_range;
    logic [15:0] vin [4];
    logic [7:0]  vexp [4];
    vin  = '{16'd256, 16'd1000, 16'd10000, 16'd40000};
    vexp = '{8'd16, 8'd31, 8'd102, 8'd204};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      R = vin[i];
      @(posedge clk); #1;
      n_vec++;
      if (final_op !== vexp[i]) begin
        n_err++;
        $display("FAIL high_range R=%0d: got %0d want %0d", vin[i], final_op, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vin [3];
    logic [7:0]  vexp [3];
    vin  = '{16'd256, 16'd65535, 16'd0};
    vexp = '{8'd16, 8'd255, 8'd0};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      R = vin[i];
      @(posedge clk); #1;
      n_vec++;
      if (final_op !== vexp[i]) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %0d want %0d", i, final_op, vexp[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    R = 16'd40000;
    @(posedge clk); #1;
    n_vec++;
    if (final_op !== 8'd204) begin
      n_err++;
      $display("FAIL mid_reset_pre: got %0d want 204", final_op);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (final_op !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: got %0d want 0", final_op);
    end
    @(negedge clk);
    rst = 1'b0;
    R   = 16'd10000;
    @(posedge clk); #1;
    n_vec++;
    if (final_op !== 8'd102) begin
      n_err++;
      $display("FAIL mid_reset_resume: got %0d want 102", final_op);
    end
  endtask

  task automatic test_sweep;
    int   want, exact, ed, n_wrong, max_ed, qh;
    real  sum_ed, sum_red;
    n_wrong = 0;
    max_ed  = 0;
    sum_ed  = 0.0;
    sum_red = 0.0;
    for (int r = 0; r < 65536; r++) begin
      @(negedge clk);
      R = r[15:0];
      @(posedge clk); #1;
      want = model(r);
      n_vec++;
      if (int'(final_op) !== want) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL sweep R=%0d: got %0d want %0d", r, final_op, want);
      end
      qh = isqrt_int(r / 256);
      if (r >= 256 && int'(final_op) < 16 * qh) begin
        n_vec++;
        n_err++;
        $display("FAIL sweep_floor R=%0d: got %0d below %0d", r, final_op, 16 * qh);
      end
      exact = isqrt_int(r);
      ed    = (int'(final_op) > exact) ? int'(final_op) - exact : exact - int'(final_op);
      if (ed != 0) n_wrong++;
      if (ed > max_ed) max_ed = ed;
      sum_ed += ed;
      if (exact > 0) sum_red += real'(ed) / real'(exact);
    end
    $display("sweep metrics: error rate %f, NMED %f, MRED %f, max ED %0d",
             real'(n_wrong) / 65536.0, sum_ed / 65536.0 / 255.0,
             sum_red / 65535.0, max_ed);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    R     = '0;
    test_reset();
    test_low_range();
    test_high_range();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
